// File: rtl/mem_stage_if.sv
// Memory-stage bundle: upstream X/M instruction, memory bus and M/W result.
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 32
);

  // upstream X/M side
  logic              in_valid;
  logic [31:0]       in_insn;
  logic [31:0]       in_o;
  logic [31:0]       in_b;
  logic              stall;

  // memory bus
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  // M/W result
  logic              out_valid;
  logic [31:0]       out_insn;
  logic [31:0]       out_o;
  logic [31:0]       out_d;
  logic              out_err;

  // the memory stage itself: drives the memory bus and the result
  modport master (
    input  in_valid, in_insn, in_o, in_b, mem_ack, mem_rdata,
    output stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           out_valid, out_insn, out_o, out_d, out_err
  );

  // the surroundings: upstream pipeline, memory and the W stage
  modport slave (
    output in_valid, in_insn, in_o, in_b, mem_ack, mem_rdata,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           out_valid, out_insn, out_o, out_d, out_err
  );

endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues one load/store at a time, stalls upstream
// while waiting for the ack, aborts on timeout, and forms the M/W result.
module mem_stage_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT     = 16,
  parameter bit          LOAD_SIGNED = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  mem_stage_if.master  bus
);

  localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_LB = 5'b01001;
  localparam logic [4:0] OP_LH = 5'b01010;
  localparam logic [4:0] OP_SB = 5'b01011;
  localparam logic [4:0] OP_SH = 5'b01100;

  localparam logic [1:0] SZ_W = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_B = 2'd2;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  // command captured at accept, used when the access completes
  logic             cmd_store;
  logic [1:0]       cmd_size;
  logic [1:0]       cmd_lane;
  logic [31:0]      cmd_insn;
  logic [31:0]      cmd_o;

  // decode of the presented instruction
  logic [4:0]       op;
  logic             is_mem;
  logic             is_store;
  logic [1:0]       size;
  logic [1:0]       lane;
  logic             misalign;
  logic [3:0]       be_dec;
  logic [31:0]      wdata_dec;
  logic             accept;
  logic             tmo_hit;
  logic [31:0]      load_data;

  // next values of the registered outputs
  logic              mem_req_nx;
  logic              mem_we_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [31:0]       mem_wdata_nx;
  logic [3:0]        mem_be_nx;
  logic              out_valid_nx;
  logic [31:0]       out_insn_nx;
  logic [31:0]       out_o_nx;
  logic [31:0]       out_d_nx;
  logic              out_err_nx;

  // stall is a direct decode of the state flop
  assign bus.stall = (state == WAIT);

  // Decode opcode, access size, alignment, lane enables and store data
  always_comb begin
    op       = bus.in_insn[31:27];
    lane     = bus.in_o[1:0];
    is_mem   = 1'b1;
    is_store = 1'b0;
    size     = SZ_W;
    case (op)
      OP_SW:   begin is_store = 1'b1; size = SZ_W; end
      OP_LW:   size = SZ_W;
      OP_LB:   size = SZ_B;
      OP_LH:   size = SZ_H;
      OP_SB:   begin is_store = 1'b1; size = SZ_B; end
      OP_SH:   begin is_store = 1'b1; size = SZ_H; end
      default: is_mem = 1'b0;
    endcase
    case (size)
      SZ_W: begin
        misalign  = (lane != 2'b00);
        be_dec    = 4'b1111;
        wdata_dec = bus.in_b;
      end
      SZ_H: begin
        misalign  = lane[0];
        be_dec    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_dec = {bus.in_b[15:0], bus.in_b[15:0]};
      end
      default: begin
        misalign  = 1'b0;
        be_dec    = 4'b0001 << lane;
        wdata_dec = {4{bus.in_b[7:0]}};
      end
    endcase
    accept  = (state == IDLE) && bus.in_valid && is_mem && !misalign;
    tmo_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TMO_LAST));
  end

  // Select and extend the returned lane for the pending load
  always_comb begin
    logic [15:0] half;
    logic [7:0]  byte_v;
    half   = cmd_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (cmd_lane)
      2'd0:    byte_v = bus.mem_rdata[7:0];
      2'd1:    byte_v = bus.mem_rdata[15:8];
      2'd2:    byte_v = bus.mem_rdata[23:16];
      default: byte_v = bus.mem_rdata[31:24];
    endcase
    case (cmd_size)
      SZ_H:    load_data = LOAD_SIGNED ? {{16{half[15]}}, half} : {16'h0000, half};
      SZ_B:    load_data = LOAD_SIGNED ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
      default: load_data = bus.mem_rdata;
    endcase
    if (cmd_store) begin
      load_data = 32'h0000_0000;
    end
  end

  // Next state and WAIT-cycle counter
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = WAIT;
          cnt_nx   = '0;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          state_nx = IDLE;
        end else if (tmo_hit) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values of memory command and M/W result
  always_comb begin
    mem_req_nx   = bus.mem_req;
    mem_we_nx    = bus.mem_we;
    mem_addr_nx  = bus.mem_addr;
    mem_wdata_nx = bus.mem_wdata;
    mem_be_nx    = bus.mem_be;
    out_valid_nx = 1'b0;
    out_insn_nx  = bus.out_insn;
    out_o_nx     = bus.out_o;
    out_d_nx     = bus.out_d;
    out_err_nx   = bus.out_err;
    case (state)
      IDLE: begin
        if (accept) begin
          mem_req_nx   = 1'b1;
          mem_we_nx    = is_store;
          mem_addr_nx  = ADDR_W'({bus.in_o[31:2], 2'b00});
          mem_wdata_nx = wdata_dec;
          mem_be_nx    = be_dec;
        end else if (bus.in_valid) begin
          out_valid_nx = 1'b1;
          out_insn_nx  = bus.in_insn;
          out_o_nx     = bus.in_o;
          out_d_nx     = 32'h0000_0000;
          out_err_nx   = is_mem;
        end
      end
      WAIT: begin
        if (bus.mem_ack || tmo_hit) begin
          mem_req_nx   = 1'b0;
          out_valid_nx = 1'b1;
          out_insn_nx  = cmd_insn;
          out_o_nx     = cmd_o;
          out_d_nx     = bus.mem_ack ? load_data : 32'h0000_0000;
          out_err_nx   = !bus.mem_ack;
        end
      end
      default: ;
    endcase
  end

  // State, counter, captured command and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      cmd_store     <= 1'b0;
      cmd_size      <= SZ_W;
      cmd_lane      <= 2'b00;
      cmd_insn      <= 32'h0000_0000;
      cmd_o         <= 32'h0000_0000;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'h0000_0000;
      bus.mem_be    <= 4'b0000;
      bus.out_valid <= 1'b0;
      bus.out_insn  <= 32'h0000_0000;
      bus.out_o     <= 32'h0000_0000;
      bus.out_d     <= 32'h0000_0000;
      bus.out_err   <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      if (accept) begin
        cmd_store <= is_store;
        cmd_size  <= size;
        cmd_lane  <= lane;
        cmd_insn  <= bus.in_insn;
        cmd_o     <= bus.in_o;
      end
      bus.mem_req   <= mem_req_nx;
      bus.mem_we    <= mem_we_nx;
      bus.mem_addr  <= mem_addr_nx;
      bus.mem_wdata <= mem_wdata_nx;
      bus.mem_be    <= mem_be_nx;
      bus.out_valid <= out_valid_nx;
      bus.out_insn  <= out_insn_nx;
      bus.out_o     <= out_o_nx;
      bus.out_d     <= out_d_nx;
      bus.out_err   <= out_err_nx;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: signed and unsigned-load instances share stimulus.
module tb_mem_stage_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  mem_stage_if #(.ADDR_W(32)) bs ();
  mem_stage_if #(.ADDR_W(32)) bu ();

  assign bu.in_valid  = bs.in_valid;
  assign bu.in_insn   = bs.in_insn;
  assign bu.in_o      = bs.in_o;
  assign bu.in_b      = bs.in_b;
  assign bu.mem_ack   = bs.mem_ack;
  assign bu.mem_rdata = bs.mem_rdata;

  mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT(4), .LOAD_SIGNED(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bs)
  );

  mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT(4), .LOAD_SIGNED(1'b0)) dut_u (
    .clock (clock),
    .reset (reset),
    .bus   (bu)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, " stall"},     32'(bs.stall),     32'd0);
    check({pfx, " mem_req"},   32'(bs.mem_req),   32'd0);
    check({pfx, " mem_we"},    32'(bs.mem_we),    32'd0);
    check({pfx, " mem_addr"},  bs.mem_addr,       32'd0);
    check({pfx, " mem_wdata"}, bs.mem_wdata,      32'd0);
    check({pfx, " mem_be"},    32'(bs.mem_be),    32'd0);
    check({pfx, " out_valid"}, 32'(bs.out_valid), 32'd0);
    check({pfx, " out_insn"},  bs.out_insn,       32'd0);
    check({pfx, " out_o"},     bs.out_o,          32'd0);
    check({pfx, " out_d"},     bs.out_d,          32'd0);
    check({pfx, " out_err"},   32'(bs.out_err),   32'd0);
  endtask

  // Present a memory op, ack when the ack_at-th request cycle is reached (0 = never)
  task automatic mem_op(input logic [4:0] op, input logic [31:0] o, input logic [31:0] b,
                        input int ack_at, input logic [31:0] rdata,
                        output int reqc, output int stallc,
                        output logic [31:0] addr, output logic [31:0] wdata,
                        output logic [3:0] be, output logic we);
    bs.in_valid = 1'b1;
    bs.in_insn  = {op, 27'h0000ABC};
    bs.in_o     = o;
    bs.in_b     = b;
    step();
    addr   = bs.mem_addr;
    wdata  = bs.mem_wdata;
    be     = bs.mem_be;
    we     = bs.mem_we;
    reqc   = 0;
    stallc = 0;
    for (int i = 0; i < 40 && bs.stall; i++) begin
      stallc++;
      if (bs.mem_req) reqc++;
      if (reqc == ack_at) begin
        bs.mem_ack   = 1'b1;
        bs.mem_rdata = rdata;
      end
      step();
      bs.mem_ack = 1'b0;
    end
    check("stall released", 32'(bs.stall), 32'd0);
    bs.in_valid = 1'b0;
  endtask

  int          reqc, stallc;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        we;

  initial begin
    bs.in_valid  = 1'b0;
    bs.in_insn   = 32'h0;
    bs.in_o      = 32'h0;
    bs.in_b      = 32'h0;
    bs.mem_ack   = 1'b0;
    bs.mem_rdata = 32'h0;

    // reset
    step();
    step();
    check_zero("reset");
    reset = 1'b1;
    step();

    // lw 0x100, ack on third WAIT cycle
    mem_op(5'b01000, 32'h100, 32'h0, 3, 32'hDEADBEEF, reqc, stallc, addr, wdata, be, we);
    check("lw req cycles",   32'(reqc),   32'd3);
    check("lw stall cycles", 32'(stallc), 32'd3);
    check("lw addr",  addr,        32'h100);
    check("lw be",    32'(be),     32'hF);
    check("lw we",    32'(we),     32'd0);
    check("lw valid", 32'(bs.out_valid), 32'd1);
    check("lw d",     bs.out_d,    32'hDEADBEEF);
    check("lw err",   32'(bs.out_err),   32'd0);
    check("lw o",     bs.out_o,    32'h100);
    check("lw insn",  bs.out_insn, {5'b01000, 27'h0000ABC});
    check("lw req low", 32'(bs.mem_req), 32'd0);
    step();
    check("lw single pulse", 32'(bs.out_valid), 32'd0);

    // sb 0x203, ack on first WAIT cycle
    mem_op(5'b01011, 32'h203, 32'h000000A5, 1, 32'h0, reqc, stallc, addr, wdata, be, we);
    check("sb req cycles", 32'(reqc), 32'd1);
    check("sb addr",  addr,      32'h200);
    check("sb be",    32'(be),   32'h8);
    check("sb wdata", wdata,     32'hA5A5A5A5);
    check("sb we",    32'(we),   32'd1);
    check("sb valid", 32'(bs.out_valid), 32'd1);
    check("sb d",     bs.out_d,  32'd0);

    // lh 0x12, upper half, signed and unsigned
    mem_op(5'b01010, 32'h12, 32'h0, 2, 32'h80017FFF, reqc, stallc, addr, wdata, be, we);
    check("lh be",       32'(be),  32'hC);
    check("lh addr",     addr,     32'h10);
    check("lh d signed", bs.out_d, 32'hFFFF8001);
    check("lh d unsig",  bu.out_d, 32'h00008001);

    // lb 0x11, lane 1
    mem_op(5'b01001, 32'h11, 32'h0, 1, 32'h123480FF, reqc, stallc, addr, wdata, be, we);
    check("lb be",       32'(be),  32'h2);
    check("lb d signed", bs.out_d, 32'hFFFFFF80);
    check("lb d unsig",  bu.out_d, 32'h00000080);

    // sh 0x2 and sw 0x40
    mem_op(5'b01100, 32'h2, 32'h1234BEEF, 1, 32'h0, reqc, stallc, addr, wdata, be, we);
    check("sh be",    32'(be), 32'hC);
    check("sh addr",  addr,    32'h0);
    check("sh wdata", wdata,   32'hBEEFBEEF);
    mem_op(5'b00111, 32'h40, 32'h11223344, 2, 32'h0, reqc, stallc, addr, wdata, be, we);
    check("sw be",    32'(be), 32'hF);
    check("sw wdata", wdata,   32'h11223344);
    check("sw we",    32'(we), 32'd1);

    // misaligned lw and lh
    bs.in_valid = 1'b1;
    bs.in_insn  = {5'b01000, 27'h0};
    bs.in_o     = 32'h102;
    step();
    check("mis lw valid", 32'(bs.out_valid), 32'd1);
    check("mis lw err",   32'(bs.out_err),   32'd1);
    check("mis lw d",     bs.out_d,          32'd0);
    check("mis lw req",   32'(bs.mem_req),   32'd0);
    check("mis lw stall", 32'(bs.stall),     32'd0);
    bs.in_insn = {5'b01010, 27'h0};
    bs.in_o    = 32'h13;
    step();
    check("mis lh err",   32'(bs.out_err),   32'd1);
    check("mis lh req",   32'(bs.mem_req),   32'd0);
    bs.in_valid = 1'b0;
    step();

    // timeout with no ack, then a stray ack in IDLE
    mem_op(5'b01000, 32'h300, 32'h0, 0, 32'h0, reqc, stallc, addr, wdata, be, we);
    check("tmo req cycles", 32'(reqc), 32'd4);
    check("tmo valid", 32'(bs.out_valid), 32'd1);
    check("tmo err",   32'(bs.out_err),   32'd1);
    check("tmo d",     bs.out_d,          32'd0);
    bs.mem_ack = 1'b1;
    step();
    bs.mem_ack = 1'b0;
    check("stray valid", 32'(bs.out_valid), 32'd0);
    check("stray err",   32'(bs.out_err),   32'd1);
    check("stray req",   32'(bs.mem_req),   32'd0);
    check("stray stall", 32'(bs.stall),     32'd0);

    // ack on the cycle the timeout would fire
    mem_op(5'b01000, 32'h310, 32'h0, 4, 32'hCAFEF00D, reqc, stallc, addr, wdata, be, we);
    check("race req cycles", 32'(reqc), 32'd4);
    check("race err", 32'(bs.out_err), 32'd0);
    check("race d",   bs.out_d,        32'hCAFEF00D);

    // five back-to-back ALU ops
    for (int i = 0; i < 5; i++) begin
      bs.in_valid = 1'b1;
      bs.in_insn  = {5'b00000, 27'(i)};
      bs.in_o     = 32'h1000 + 32'(i);
      step();
      check("alu valid", 32'(bs.out_valid), 32'd1);
      check("alu o",     bs.out_o,          32'h1000 + 32'(i));
      check("alu insn",  bs.out_insn,       {5'b00000, 27'(i)});
      check("alu d",     bs.out_d,          32'd0);
      check("alu stall", 32'(bs.stall),     32'd0);
    end
    bs.in_valid = 1'b0;
    step();

    // reset in the middle of a WAIT
    bs.in_valid = 1'b1;
    bs.in_insn  = {5'b01000, 27'h0};
    bs.in_o     = 32'h500;
    step();
    check("pre-reset stall", 32'(bs.stall), 32'd1);
    reset = 1'b0;
    step();
    check_zero("mid-wait reset");
    reset       = 1'b1;
    bs.in_valid = 1'b0;
    bs.mem_ack  = 1'b1;
    step();
    bs.mem_ack = 1'b0;
    check("abandoned valid", 32'(bs.out_valid), 32'd0);
    check("abandoned req",   32'(bs.mem_req),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: width of mem_addr; the low ADDR_W bits of in_o are the address.
REQ-002 Parameter TIMEOUT, default 16: maximum WAIT cycles before abort; 0 disables the timeout.
REQ-003 Parameter LOAD_SIGNED, default 1: 1 = lb/lh sign-extend, 0 = lb/lh zero-extend.
REQ-004 Clock and reset SHALL be a single clock and a synchronous, active-low reset, exactly as follows.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 in_valid  input  1  an X/M instruction is presented.
REQ-008 in_insn  input  32  instruction; opcode = in_insn[31:27].
REQ-009 in_o  input  32  ALU result / effective address.
REQ-010 in_b  input  32  store data (rt value).
REQ-011 stall  output  1  upstream SHALL hold in_* while high.
REQ-012 mem_req  output  1  memory request, held until mem_ack.
REQ-013 mem_we  output  1  1 = store.
REQ-014 mem_addr  output  ADDR_W  word-aligned address (low 2 bits forced 0).
REQ-015 mem_wdata  output  32  lane-replicated store data.
REQ-016 mem_be  output  4  byte enables.
REQ-017 mem_ack  input  1  request completes this cycle; mem_rdata valid.
REQ-018 mem_rdata  input  32  read word.
REQ-019 out_valid, out_insn[32], out_o[32], out_d[32], out_err[1]  outputs  registered M/W result; out_o = in_o passthrough, out_d = load data.

Function
REQ-020 Opcodes SHALL be: sw 00111, lw 01000, lb 01001, lh 01010, sb 01011, sh 01100; all others non-memory.
REQ-021 FSM SHALL have states IDLE and WAIT; stall = (state == WAIT).
REQ-022 IDLE, in_valid, non-memory op: next edge out_valid=1, out_insn/out_o copied, out_d=0, out_err=0; throughput 1/cycle.
REQ-023 IDLE, in_valid=0: next edge out_valid=0; other out_* hold.
REQ-024 Misaligned access (lw/sw addr[1:0]!=0; lh/sh addr[0]!=0): no mem_req; next edge out_valid=1, out_err=1, out_d=0.
REQ-025 IDLE, aligned memory op accepted at edge T: command registered, state -> WAIT, mem_req=1 from T+1 until the ack cycle inclusive; mem_* outputs stable throughout.
REQ-026 mem_ack sampled high in WAIT at edge T+k (k>=1): state -> IDLE, mem_req=0, out_valid=1 for one cycle, out_err=0; next instruction accepted at the first edge after that.
REQ-027 Byte enables: sw/lw 1111; sh/lh 0011 (addr[1]=0) or 1100 (addr[1]=1); sb/lb 0001<<addr[1:0].
REQ-028 mem_wdata: sw = in_b; sh = {in_b[15:0], in_b[15:0]}; sb = in_b[7:0] replicated 4x.
REQ-029 out_d: lw = mem_rdata; lh/lb = selected lane extended per LOAD_SIGNED; stores out_d=0.
REQ-030 Timeout counter SHALL clear on entering WAIT and increment each WAIT cycle without ack; on reaching TIMEOUT (nonzero): mem_req drops, state -> IDLE, out_valid=1, out_err=1, out_d=0.
REQ-031 mem_ack and TIMEOUT in the same cycle: ack wins, normal completion.
REQ-032 mem_ack while IDLE SHALL be ignored (no output change).
REQ-033 out_valid SHALL be high for exactly one cycle per accepted instruction.

Reset
REQ-034 reset=0 at an edge: state=IDLE, counter=0, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, all out_* = 0.
REQ-035 Reset during WAIT SHALL abandon the transaction; no out_valid is produced for it.

Verification
REQ-036 lw, in_o=0x100, ack after 3 WAIT cycles with rdata=0xDEADBEEF -> mem_req high 3 cycles, mem_be=1111, stall high 3 cycles, out_d=0xDEADBEEF, out_err=0.
REQ-037 sb, in_o=0x203, in_b=0x000000A5, ack on first WAIT cycle -> mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1.
REQ-038 lh, in_o=0x12, rdata=0x8001_7FFF -> out_d=0xFFFF8001 (LOAD_SIGNED=1) / 0x00008001 (LOAD_SIGNED=0).
REQ-039 lw, in_o=0x102 -> no mem_req, out_valid=1, out_err=1, next cycle.
REQ-040 TIMEOUT=4, no ack -> mem_req high 4 cycles then low, out_err=1; later stray ack ignored.
REQ-041 Back-to-back ALU ops for 5 cycles -> 5 consecutive out_valid pulses, stall=0; reset asserted mid-WAIT -> mem_req=0 and all outputs 0 after that edge.
